// File: rtl/rem_bcd_conv.sv
// rem_bcd_conv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// It captures an N-bit remainder on an accepted start and converts it over N clock cycles.
// It then presents packed BCD digits together with a one-cycle done pulse.
// Digit 0 sits in bcd[3:0] and digit k sits in bcd[4k+3:4k].

module rem_bcd_conv #(
  parameter int N      = 7,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int SREG_W = BCD_W + N;
  localparam int CNT_W  = $clog2(N) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // The digit field must be wide enough to hold the largest binary input.
  if (10**DIGITS <= 2**N - 1) begin : g_digits_check
    $error("rem_bcd_conv: DIGITS too small to represent 2**N-1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SREG_W-1:0]    sreg_q,  sreg_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [BCD_W-1:0]     bcd_q,   bcd_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;

  logic [SREG_W-1:0]    adj_s;
  logic [SREG_W-1:0]    shifted_s;

  // Add 3 to every BCD nibble holding 5 or more.
  // All nibbles are judged on the same pre-shift value, so they are adjusted in parallel.
  function automatic logic [SREG_W-1:0] dabble_adjust(input logic [SREG_W-1:0] v);
    logic [SREG_W-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[N + 4*k +: 4] >= 4'd5) begin
        r[N + 4*k +: 4] = v[N + 4*k +: 4] + 4'd3;
      end else begin
        r[N + 4*k +: 4] = v[N + 4*k +: 4];
      end
    end
    return r;
  endfunction

  // Datapath for one double-dabble step: adjust the nibbles, then shift left by one.
  always_comb begin
    adj_s     = dabble_adjust(sreg_q);
    shifted_s = {adj_s[SREG_W-2:0], 1'b0};
  end

  // Next-state logic, datapath register updates and output decodes.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sreg_d  = {{BCD_W{1'b0}}, bin};
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        sreg_d = shifted_s;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // The result is taken from the final shift.
          // This makes bcd valid in the same cycle that done is high.
          bcd_d   = shifted_s[SREG_W-1 -: BCD_W];
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy and done are decodes of the state, registered alongside it.
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers.
  // An asynchronous reset aborts any conversion and clears the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sreg_q  <= {SREG_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      bcd_q   <= {BCD_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
